// File: rtl/face_pkg.sv
// Shared definitions for the face_dispatch command dispatcher: instruction
// encodings, engine mode codes, FSM state codes and the default-width queue
// entry layout.
package face_pkg;

  localparam logic [6:0] SYSOPCODE             = 7'b0001011;
  localparam logic [2:0] systolic_addrset_FUNC = 3'b001;
  localparam logic [2:0] systolic_calc_FUNC    = 3'b010;

  // Base-register selector carried in instr[11:10] of an addrset word.
  localparam logic [1:0] SEL_LEFT   = 2'b00;
  localparam logic [1:0] SEL_RIGHT  = 2'b01;
  localparam logic [1:0] SEL_ADDSRC = 2'b10;
  localparam logic [1:0] SEL_SAVE   = 2'b11;

  typedef enum logic [1:0] {
    AS = 2'b00,
    SB = 2'b01,
    BS = 2'b10,
    SA = 2'b11
  } face_mode_e;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_FIN   = 2'd3;

  localparam int FACE_ADDR_W = 32;
  localparam int FACE_SIZE_W = 11;

  // Queue entry at the default widths; the top re-declares the same layout
  // sized from its own ADDR_W/SIZE_W parameters.
  typedef struct packed {
    face_mode_e             mode;
    logic [FACE_SIZE_W-1:0] size;
    logic [FACE_ADDR_W-1:0] base_left;
    logic [FACE_ADDR_W-1:0] base_right;
    logic [FACE_ADDR_W-1:0] base_addsrc;
    logic [FACE_ADDR_W-1:0] base_save;
  } face_entry_t;

endpackage

// File: rtl/face_cmd_fifo.sv
// Calc command queue: power-of-two depth FIFO of an arbitrary packed entry
// type. Pointers wrap naturally at DEPTH; push on full and pop on empty are
// dropped. Storage is not reset, only pointers and occupancy.
module face_cmd_fifo
  import face_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = face_entry_t,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  T              push_data_i,
  input  logic          pop_i,
  output T              pop_data_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  T              mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Pointer and occupancy tracking; simultaneous push/pop leaves count as is.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Entry storage write.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign pop_data_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;

endmodule

// File: rtl/face_dispatch.sv
// face_dispatch: decodes systolic instructions, keeps the four base-address
// registers, queues calc commands and launches them one at a time on the
// engine. Optional RUN-cycle counter enabled by FACE_DISPATCH_PERF_EN.
//
// state    | meaning
// ---------+--------------------------------------------------------
// ST_IDLE  | waiting for a queued calc; pops head into eng_* regs
// ST_ISSUE | eng_start high for this single cycle
// ST_RUN   | engine working; waits for eng_done
// ST_FIN   | done high for this single cycle
module face_dispatch
  import face_pkg::*;
#(
  parameter int  QDEPTH = 4,
  parameter int  ADDR_W = 32,
  parameter int  SIZE_W = 11,
  localparam int CW     = $clog2(QDEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic              err_clr,
  output logic              eng_start,
  output logic [1:0]        eng_mode,
  output logic [SIZE_W-1:0] eng_size,
  output logic [ADDR_W-1:0] eng_base_left,
  output logic [ADDR_W-1:0] eng_base_right,
  output logic [ADDR_W-1:0] eng_base_addsrc,
  output logic [ADDR_W-1:0] eng_base_save,
  input  logic              eng_done,
  output logic              done,
  output logic              busy,
  output logic [CW-1:0]     q_count,
  output logic              err,
  output logic [31:0]       perf_run_cycles
);

  typedef struct packed {
    face_mode_e        mode;
    logic [SIZE_W-1:0] size;
    logic [ADDR_W-1:0] base_left;
    logic [ADDR_W-1:0] base_right;
    logic [ADDR_W-1:0] base_addsrc;
    logic [ADDR_W-1:0] base_save;
  } entry_t;

  logic [ADDR_W-1:0] left_q, right_q, addsrc_q, save_q;
  logic [1:0]        state_q, state_d;
  logic              err_q;
  entry_t            push_entry, pop_entry;
  logic              fifo_full, fifo_empty, pop;

  logic              accept, is_sys, is_set, is_calc, push, err_set;
  logic [2:0]        func;
  logic [1:0]        sel;
  logic [SIZE_W-1:0] calc_size;
  logic [ADDR_W-1:0] payload_addr;
  logic              unused_instr_msb;

  assign unused_instr_msb = instr[31];

  assign func         = instr[9:7];
  assign sel          = instr[11:10];
  assign calc_size    = instr[12+SIZE_W-1:12];
  assign payload_addr = ADDR_W'(instr[30:12]);

  assign instr_ready = ~fifo_full;
  assign accept      = instr_valid & instr_ready;
  assign is_sys      = accept & (instr[6:0] == SYSOPCODE);
  assign is_set      = is_sys & (func == systolic_addrset_FUNC);
  assign is_calc     = is_sys & (func == systolic_calc_FUNC);
  assign push        = is_calc & (calc_size != '0);
  assign err_set     = (is_calc & (calc_size == '0)) | (is_sys & ~is_set & ~is_calc);

  // Calc snapshots the base registers as they read in the accept cycle.
  assign push_entry = '{mode:        face_mode_e'(sel),
                        size:        calc_size,
                        base_left:   left_q,
                        base_right:  right_q,
                        base_addsrc: addsrc_q,
                        base_save:   save_q};

  face_cmd_fifo #(
    .DEPTH (QDEPTH),
    .T     (entry_t)
  ) u_cmd_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .pop_data_o  (pop_entry),
    .count_o     (q_count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // Base-address registers written by addrset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      left_q   <= '0;
      right_q  <= '0;
      addsrc_q <= '0;
      save_q   <= '0;
    end else if (is_set) begin
      case (sel)
        SEL_LEFT:   left_q   <= payload_addr;
        SEL_RIGHT:  right_q  <= payload_addr;
        SEL_ADDSRC: addsrc_q <= payload_addr;
        SEL_SAVE:   save_q   <= payload_addr;
        default:    left_q   <= left_q;
      endcase
    end
  end

  // Sticky error: a new error in the same cycle beats err_clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       err_q <= 1'b0;
    else if (err_set) err_q <= 1'b1;
    else if (err_clr) err_q <= 1'b0;
  end

  // Next-state and pop decision; eng_done is only looked at in RUN.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_RUN;
      ST_RUN:   if (eng_done) state_d = ST_FIN;
      ST_FIN:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Engine command registers; hold until the next pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eng_mode        <= '0;
      eng_size        <= '0;
      eng_base_left   <= '0;
      eng_base_right  <= '0;
      eng_base_addsrc <= '0;
      eng_base_save   <= '0;
    end else if (pop) begin
      eng_mode        <= pop_entry.mode;
      eng_size        <= pop_entry.size;
      eng_base_left   <= pop_entry.base_left;
      eng_base_right  <= pop_entry.base_right;
      eng_base_addsrc <= pop_entry.base_addsrc;
      eng_base_save   <= pop_entry.base_save;
    end
  end

  assign eng_start = (state_q == ST_ISSUE);
  assign done      = (state_q == ST_FIN);
  assign busy      = (state_q != ST_IDLE) | (q_count != '0);
  assign err       = err_q;

`ifdef FACE_DISPATCH_PERF_EN
  logic [31:0] perf_q;

  // Saturating count of cycles spent in RUN; cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                     perf_q <= '0;
    else if ((state_q == ST_RUN) && (perf_q != '1)) perf_q <= perf_q + 32'd1;
  end

  assign perf_run_cycles = perf_q;
`else
  assign perf_run_cycles = '0;
`endif

endmodule
